// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath, with memory wait states and precise exceptions.
// Latency: fetch and memory states last 1+MEM_WAIT cycles; every other state lasts one cycle.
// Backpressure: none. While reset is high, every strobe is forced low.
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    output logic [1:0] pc_src,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [2:0] ula_sel,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_load,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       epc_write,
    output logic       cause,
    output logic [4:0] state_o
);

    typedef enum logic [4:0] {
        S_START     = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_R_EXEC    = 5'd3,
        S_R_WB      = 5'd4,
        S_ADDI_EXEC = 5'd5,
        S_ADDI_WB   = 5'd6,
        S_MEM_ADDR  = 5'd7,
        S_MEM_RD    = 5'd8,
        S_LW_WB     = 5'd9,
        S_MEM_WR    = 5'd10,
        S_BRANCH    = 5'd11,
        S_JUMP      = 5'd12,
        S_EXC_OP    = 5'd13,
        S_EXC_OVF   = 5'd14
    } state_t;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [2:0] ula_sel;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_load;
        logic       reg_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       epc_write;
        logic       cause;
    } ctl_t;

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             in_mem, wait_done;
    logic [2:0]       r_sel;
    logic             r_valid, r_arith;
    ctl_t             ctl, ctl_q;

    assign in_mem    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign wait_done = (cnt == WAIT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_START;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (in_mem && !wait_done) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        r_sel   = 3'b000;
        r_valid = 1'b1;
        r_arith = 1'b0;
        case (funct)
            6'h20:   begin r_sel = 3'b001; r_arith = 1'b1; end
            6'h22:   begin r_sel = 3'b010; r_arith = 1'b1; end
            6'h24:   r_sel = 3'b011;
            6'h26:   r_sel = 3'b110;
            default: r_valid = 1'b0;
        endcase
    end

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        case (state)
            S_START: state_nxt = S_FETCH;
            S_FETCH: begin
                ctl.ula_src_b = 2'b01;
                ctl.ula_sel   = 3'b001;
                if (wait_done) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.ula_src_b = 2'b11;
                ctl.ula_sel   = 3'b001;
                case (opcode)
                    6'h00:       state_nxt = S_R_EXEC;
                    6'h23, 6'h2B: state_nxt = S_MEM_ADDR;
                    6'h04, 6'h05: state_nxt = S_BRANCH;
                    6'h02:       state_nxt = S_JUMP;
                    6'h08:       state_nxt = S_ADDI_EXEC;
                    default:     state_nxt = S_EXC_OP;
                endcase
            end
            S_R_EXEC: begin
                ctl.ula_src_a = 1'b1;
                ctl.ula_sel   = r_sel;
                if (!r_valid)                 state_nxt = S_EXC_OP;
                else if (overflow && r_arith) state_nxt = S_EXC_OVF;
                else                          state_nxt = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctl.ula_src_a = 1'b1;
                ctl.ula_src_b = 2'b10;
                ctl.ula_sel   = 3'b001;
                state_nxt     = overflow ? S_EXC_OVF : S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.ula_src_a = 1'b1;
                ctl.ula_src_b = 2'b10;
                ctl.ula_sel   = 3'b001;
                state_nxt     = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.iord = 1'b1;
                if (wait_done) begin
                    ctl.mdr_load = 1'b1;
                    state_nxt    = S_LW_WB;
                end
            end
            S_LW_WB: begin
                ctl.reg_write = 1'b1;
                ctl.mem2reg   = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                if (wait_done) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ctl.ula_src_a     = 1'b1;
                ctl.ula_sel       = 3'b010;
                ctl.pc_src        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.branch_ne     = opcode[0];
                state_nxt         = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_src   = 2'b10;
                ctl.pc_write = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_EXC_OP, S_EXC_OVF: begin
                // ULA computes PC-4 so EPC captures the faulting instruction address
                ctl.ula_src_b = 2'b01;
                ctl.ula_sel   = 3'b010;
                ctl.epc_write = 1'b1;
                ctl.cause     = (state == S_EXC_OVF);
                ctl.pc_src    = 2'b11;
                ctl.pc_write  = 1'b1;
                state_nxt     = S_FETCH;
            end
            default: state_nxt = S_START;
        endcase
    end

    assign ctl_q         = reset ? '0 : ctl;
    assign pc_src        = ctl_q.pc_src;
    assign ula_src_a     = ctl_q.ula_src_a;
    assign ula_src_b     = ctl_q.ula_src_b;
    assign ula_sel       = ctl_q.ula_sel;
    assign iord          = ctl_q.iord;
    assign mem_write     = ctl_q.mem_write;
    assign ir_write      = ctl_q.ir_write;
    assign mdr_load      = ctl_q.mdr_load;
    assign reg_write     = ctl_q.reg_write;
    assign reg_dst       = ctl_q.reg_dst;
    assign mem2reg       = ctl_q.mem2reg;
    assign pc_write      = ctl_q.pc_write;
    assign pc_write_cond = ctl_q.pc_write_cond;
    assign branch_ne     = ctl_q.branch_ne;
    assign epc_write     = ctl_q.epc_write;
    assign cause         = ctl_q.cause;
    assign state_o       = state;

endmodule
